fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage directly downstream of the pc register.
//   - Reads the current PC (pc_q), issues a single instruction-memory request and
//     captures the response into an output register.
//   - Presents the captured instruction to decode over a valid/ready handshake.
//   - Drives pc_d/pc_en back into pc: sequential increment or redirect (branch/jump).
// PARAMETERS
//   WIDTH    8   PC / instruction address width (matches pc WIDTH)
//   INSTR_W  16  instruction word width
// PORTS
//   clk             in   1        system clock, rising edge
//   reset           in   1        asynchronous, active-high reset
//   pc_q            in   WIDTH    current PC from pc register
//   pc_d            out  WIDTH    next PC value to pc register
//   pc_en           out  1        pc load enable (pc_q := pc_d next edge)
//   redirect_valid  in   1        branch/jump taken this cycle
//   redirect_pc     in   WIDTH    target address for redirect
//   imem_req_valid  out  1        memory request valid
//   imem_req_ready  in   1        memory accepts request
//   imem_req_addr   out  WIDTH    request address
//   imem_rsp_valid  in   1        response valid (in order, >=1 cycle after accept)
//   imem_rsp_data   in   INSTR_W  response instruction word
//   instr_valid     out  1        instruction available to decode (registered)
//   instr_ready     in   1        decode accepts instruction
//   instr           out  INSTR_W  fetched instruction (registered)
//   instr_pc        out  WIDTH    address instr was fetched from (registered)
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE.
//     - instr_valid=0, instr=0, instr_pc=0.
//     - Combinational outputs in IDLE: pc_en=0, imem_req_valid=0.
//   At most one memory request outstanding. FSM: IDLE, REQ, WAIT, HOLD, DRAIN.
//   IDLE:  next edge -> REQ.
//   REQ:   imem_req_valid=1, imem_req_addr=pc_q.
//          - Accept (valid&ready) -> WAIT; latch pc_q into an internal addr reg.
//   WAIT:  on imem_rsp_valid:
//          - instr<=rsp_data, instr_pc<=addr reg, instr_valid<=1.
//          - pc_en=1, pc_d=pc_q+1 (mod 2^WIDTH; 0xFF -> 0x00).
//          - -> HOLD.
//   HOLD:  instr_valid held; instr/instr_pc stable.
//          - On instr_valid&instr_ready: instr_valid<=0, -> REQ.
//   DRAIN: discard the next imem_rsp_valid (no capture, no pc_en), then -> REQ.
//   Redirect (redirect_valid=1) takes priority in every state except IDLE-reset:
//     - pc_en=1, pc_d=redirect_pc (overrides increment in WAIT).
//     - Clears instr_valid next edge.
//     - REQ:   imem_req_valid forced 0 that cycle; stay REQ.
//              Next request uses the updated pc_q.
//     - WAIT:  if imem_rsp_valid same cycle -> discard, -> REQ; else -> DRAIN.
//     - HOLD:  -> REQ. Simultaneous instr_ready handshake counts as consumed.
//     - DRAIN: update PC, stay DRAIN.
//     - IDLE:  update PC, -> REQ.
//   Latency, no stalls: REQ accept -> rsp -> instr_valid the edge after rsp.
//     Back-to-back fetch every 3 cycles with 1-cycle memory.
//   pc_en is only ever asserted for one cycle per event.
//   Reset mid-operation:
//     - Outstanding response after reset deassertion is ignored in IDLE/REQ.
//     - Memory is reset together with this block.
// TESTING
//   1 Reset, pc_q=0x00, mem[0]=0x1234, 1-cycle mem, ready=1
//     -> req addr 0x00; pc_d=0x01 with pc_en 1 cycle; instr=0x1234, instr_pc=0x00.
//   2 instr_ready=0 for 5 cycles in HOLD
//     -> instr_valid stays 1, instr stable, no new imem_req_valid.
//     -> After ready=1: next req addr=0x01.
//   3 pc_q=0xFF fetch
//     -> pc_d=0x00, pc_en=1; instr_pc=0xFF.
//   4 redirect_pc=0x40 asserted while in WAIT, response 2 cycles later
//     -> pc_d=0x40, state DRAIN; stale response dropped (instr_valid stays 0).
//     -> Next req addr=0x40.
//   5 redirect_pc=0x10 in HOLD with instr_ready=1 same cycle
//     -> instr_valid=0 next edge, pc_d=0x10, next req addr=0x10.
//   6 imem_req_ready=0 for 3 cycles
//     -> imem_req_valid and imem_req_addr held; pc_en=0.
//   7 Assert reset during WAIT
//     -> instr_valid=0 immediately; state IDLE.
//     -> After release: fresh request at current pc_q.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests the word at pc_q, registers the response
// for decode and steers the pc register (increment or redirect).
module fetch_unit #(
    parameter int WIDTH   = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   pc_q,
    output logic [WIDTH-1:0]   pc_d,
    output logic               pc_en,
    input  logic               redirect_valid,
    input  logic [WIDTH-1:0]   redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [WIDTH-1:0]   imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [WIDTH-1:0]   instr_pc
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [WIDTH-1:0] addr_q;
    logic             req_fire;
    logic             rsp_take;

    assign imem_req_addr = pc_q;
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign rsp_take      = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;

    // PC steering and request valid; a redirect wins over everything
    always_comb begin
        pc_en          = 1'b0;
        pc_d           = pc_q + WIDTH'(1);
        imem_req_valid = 1'b0;
        if (redirect_valid) begin
            pc_en = 1'b1;
            pc_d  = redirect_pc;
        end else if (rsp_take) begin
            pc_en = 1'b1;
        end
        if (state == S_REQ && !redirect_valid) begin
            imem_req_valid = 1'b1;
        end
    end

    // Next-state selection for the single-outstanding-request FSM
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                if (!redirect_valid && req_fire) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (redirect_valid)
                    state_nxt = imem_rsp_valid ? S_REQ : S_DRAIN;
                else if (imem_rsp_valid)
                    state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (redirect_valid || instr_ready) state_nxt = S_REQ;
            end
            S_DRAIN: begin
                // the in-flight response is dropped even if a redirect arrives with it
                if (imem_rsp_valid) state_nxt = S_REQ;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Request address latch and registered instruction output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            if (state == S_REQ && req_fire) begin
                addr_q <= pc_q;
            end
            if (redirect_valid) begin
                instr_valid <= 1'b0;
            end else if (rsp_take) begin
                instr       <= imem_rsp_data;
                instr_pc    <= addr_q;
                instr_valid <= 1'b1;
            end else if (state == S_HOLD && instr_ready) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural pc register and a
// fixed-latency instruction memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pc_q = 8'h00;
    logic [7:0]  pc_d;
    logic        pc_en;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [7:0]  imem_req_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  instr_pc;

    logic [15:0] mem [256];
    logic        busy;
    logic [3:0]  cnt;
    logic [7:0]  addr_l;
    logic [3:0]  lat;

    int n_vec = 0;
    int n_err = 0;

    fetch_unit #(.WIDTH(8), .INSTR_W(16)) dut (
        .clk(clk),
        .reset(reset),
        .pc_q(pc_q),
        .pc_d(pc_d),
        .pc_en(pc_en),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    // pc register loaded by the fetch unit
    always @(posedge clk) begin
        if (pc_en) pc_q <= pc_d;
    end

    // memory: response valid lat cycles after accept
    assign imem_rsp_valid = busy && (cnt == 4'd1);
    assign imem_rsp_data  = mem[addr_l];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy   <= 1'b0;
            cnt    <= 4'd0;
            addr_l <= 8'h00;
        end else begin
            if (busy) begin
                if (cnt == 4'd1) busy <= 1'b0;
                else             cnt  <= cnt - 4'd1;
            end
            if (imem_req_valid && imem_req_ready) begin
                busy   <= 1'b1;
                cnt    <= lat;
                addr_l <= imem_req_addr;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        mem[8'h00] = 16'h1234;
        mem[8'hFF] = 16'hBEEF;
        lat            = 4'd1;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;

        // reset state
        step(); step();
        check("rst_ivalid", 32'(instr_valid), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_ipc", 32'(instr_pc), 32'd0);
        check("rst_req", 32'(imem_req_valid), 32'd0);
        check("rst_pcen", 32'(pc_en), 32'd0);

        // 1: basic fetch from 0x00
        reset = 1'b0;
        #1;
        check("idle_req", 32'(imem_req_valid), 32'd0);
        step();
        check("t1_req", 32'(imem_req_valid), 32'd1);
        check("t1_addr", 32'(imem_req_addr), 32'h00);
        check("t1_pcen_req", 32'(pc_en), 32'd0);
        step();
        check("t1_pcen", 32'(pc_en), 32'd1);
        check("t1_pcd", 32'(pc_d), 32'h01);
        check("t1_ivalid_wait", 32'(instr_valid), 32'd0);
        step();
        check("t1_ivalid", 32'(instr_valid), 32'd1);
        check("t1_instr", 32'(instr), 32'h1234);
        check("t1_ipc", 32'(instr_pc), 32'h00);
        check("t1_pcen_once", 32'(pc_en), 32'd0);

        // 2: decode stalls five cycles in HOLD
        for (int i = 0; i < 5; i++) begin
            check("t2_ivalid", 32'(instr_valid), 32'd1);
            check("t2_instr", 32'(instr), 32'h1234);
            check("t2_noreq", 32'(imem_req_valid), 32'd0);
            if (i < 4) step();
        end
        instr_ready = 1'b1;
        step();
        check("t2_ivalid_clr", 32'(instr_valid), 32'd0);
        check("t2_req", 32'(imem_req_valid), 32'd1);
        check("t2_addr", 32'(imem_req_addr), 32'h01);

        // 6: memory not ready for three cycles
        imem_req_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t6_req", 32'(imem_req_valid), 32'd1);
            check("t6_addr", 32'(imem_req_addr), 32'h01);
            check("t6_pcen", 32'(pc_en), 32'd0);
            step();
        end
        imem_req_ready = 1'b1;
        step();
        check("t6_pcd", 32'(pc_d), 32'h02);
        step();
        check("t6_instr", 32'(instr), 32'h1001);
        check("t6_ipc", 32'(instr_pc), 32'h01);
        step();

        // 3: PC wrap from 0xFF
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFF;
        #1;
        check("t3_req_blk", 32'(imem_req_valid), 32'd0);
        check("t3_pcen_rd", 32'(pc_en), 32'd1);
        check("t3_pcd_rd", 32'(pc_d), 32'hFF);
        step();
        redirect_valid = 1'b0;
        #1;
        check("t3_addr", 32'(imem_req_addr), 32'hFF);
        check("t3_req", 32'(imem_req_valid), 32'd1);
        step();
        check("t3_pcen", 32'(pc_en), 32'd1);
        check("t3_pcd", 32'(pc_d), 32'h00);
        step();
        check("t3_instr", 32'(instr), 32'hBEEF);
        check("t3_ipc", 32'(instr_pc), 32'hFF);
        step();

        // 4: redirect in WAIT, stale response dropped
        lat = 4'd3;
        check("t4_addr0", 32'(imem_req_addr), 32'h00);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        #1;
        check("t4_pcen", 32'(pc_en), 32'd1);
        check("t4_pcd", 32'(pc_d), 32'h40);
        step();
        redirect_valid = 1'b0;
        #1;
        check("t4_drain_pcen", 32'(pc_en), 32'd0);
        check("t4_drain_req", 32'(imem_req_valid), 32'd0);
        step();
        check("t4_rsp_seen", 32'(imem_rsp_valid), 32'd1);
        check("t4_drop_pcen", 32'(pc_en), 32'd0);
        step();
        check("t4_ivalid", 32'(instr_valid), 32'd0);
        check("t4_req", 32'(imem_req_valid), 32'd1);
        check("t4_addr", 32'(imem_req_addr), 32'h40);
        lat = 4'd1;

        // 5: redirect in HOLD alongside a decode handshake
        step();
        step();
        check("t5_instr", 32'(instr), 32'h1040);
        check("t5_ivalid", 32'(instr_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h10;
        #1;
        check("t5_pcen", 32'(pc_en), 32'd1);
        check("t5_pcd", 32'(pc_d), 32'h10);
        step();
        redirect_valid = 1'b0;
        #1;
        check("t5_ivalid_clr", 32'(instr_valid), 32'd0);
        check("t5_req", 32'(imem_req_valid), 32'd1);
        check("t5_addr", 32'(imem_req_addr), 32'h10);

        // 7: reset during WAIT, then a fresh fetch
        lat = 4'd3;
        step();
        check("t7_wait_req", 32'(imem_req_valid), 32'd0);
        reset = 1'b1;
        #1;
        check("t7_rst_pcen", 32'(pc_en), 32'd0);
        check("t7_rst_ivalid", 32'(instr_valid), 32'd0);
        step();
        reset = 1'b0;
        lat   = 4'd1;
        #1;
        check("t7_idle_req", 32'(imem_req_valid), 32'd0);
        step();
        check("t7_req", 32'(imem_req_valid), 32'd1);
        check("t7_addr", 32'(imem_req_addr), 32'h10);
        instr_ready = 1'b0;
        step();
        step();
        check("t7_instr", 32'(instr), 32'h1010);
        check("t7_ipc", 32'(instr_pc), 32'h10);

        // reset while HOLD clears the output register at once
        reset = 1'b1;
        #1;
        check("t7_hold_ivalid", 32'(instr_valid), 32'd0);
        check("t7_hold_instr", 32'(instr), 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
